audio_serializer: RTL and testbench
===================================

Name: audio_serializer

Overview:
- Parametrised successor of the fixed-format RJ transmitter.
- Serialises stereo PCM samples onto lrck/bck/d in I2S, left-justified (LJ) or right-justified (RJ) format. The format is selectable per frame.
- Bit clock is generated internally from clk by a divider; the transmitter is no longer tied to an inverted system clock.
- A one-deep holding register with a valid/ready handshake decouples the upstream sample source; underrun is reported.

Parameters:
- SLOT_BITS, 32, bits per channel slot; a frame is 2*SLOT_BITS bck periods.
- SAMPLE_BITS, 24, bits per channel sample; constraint 1 <= SAMPLE_BITS <= SLOT_BITS-1.
- HALF_DIV, 2, clk cycles per bck half-period (>=1); bck period = 2*HALF_DIV clk cycles.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  run enable; 0 holds the serial interface idle.
- fmt  in  2  0=I2S, 1=LJ, 2=RJ; 3 is treated as LJ. Sampled at frame start only.
- s_data  in  2*SAMPLE_BITS  high word = left channel, low word = right channel.
- s_valid  in  1  s_data valid.
- s_ready  out  1  holding register empty; transfer on s_valid & s_ready.
- lrck  out  1  word select, registered.
- bck  out  1  bit clock, registered.
- d  out  1  serial data MSB-first, registered.
- frame_start  out  1  one-clk pulse when a frame's first bit is driven.
- underrun  out  1  one-clk pulse at frame start when no sample was held.

Behaviour:
- Reset values:
  - Outputs: bck=0, lrck=0, d=0, s_ready=1, frame_start=0, underrun=0.
  - Internal: div_cnt=0, bit_cnt=2*SLOT_BITS-1, holding register empty, shift register 0, latched format=LJ.
- Divider:
  - While en=1, div_cnt counts 0..HALF_DIV-1.
  - At HALF_DIV-1, div_cnt wraps and bck toggles.
- Falling-edge event:
  - Defined as the clk cycle in which bck toggles 1->0.
  - On this event bit_cnt advances, wrapping 2*SLOT_BITS-1 -> 0, and d and lrck update in the same cycle as the bck falling edge.
  - Receivers sample on the bck rising edge. d and lrck never change on a rising edge.
- First frame after reset or enable: the first falling edge occurs 2*HALF_DIV clk cycles after en=1 and begins frame 0 (bit_cnt=0).
- Frame start (falling edge with bit_cnt wrapping to 0):
  - Latch fmt.
  - If the holding register is full, load the shift image from it and mark the holding register empty.
  - If the holding register is empty, load an all-zero image and pulse underrun.
  - Pulse frame_start in both cases.
- Shift image, per slot; bit 0 is the first transmitted bit. Unused slot bits are 0.
  - LJ: sample MSB at slot bit 0.
  - I2S: sample MSB at slot bit 1 (one-bck delay); slot bit 0 is 0.
  - RJ: sample LSB at slot bit SLOT_BITS-1; MSB at bit SLOT_BITS-SAMPLE_BITS.
- lrck:
  - LJ and RJ: lrck=1 during the left slot (bit_cnt < SLOT_BITS), 0 during the right slot.
  - I2S: inverted, lrck=0 during the left slot.
- Handshake:
  - s_ready = holding register empty.
  - A sample accepted in the frame-start cycle when the register was empty is not bypassed: that frame still underruns, and the sample is sent in the next frame.
  - In a frame-start cycle with the register full, s_ready was 0, so nothing is accepted. s_ready rises the following cycle.
- fmt changes mid-frame have no effect until the next frame start.
- en=0, taking effect the next cycle:
  - bck=0, d=0, lrck=0.
  - div_cnt and bit_cnt return to their reset values.
  - Holding-register contents and the handshake are preserved.
  - No underrun or frame_start pulses.
- rst mid-frame: everything returns to reset values the next cycle, and any held sample is discarded.

Test Plan:
- SLOT=32, SAMPLE=24, HALF_DIV=2, LJ, send L=0xABCDEF, R=0x123456.
  - bck period 4 clk; frame_start every 256 clk.
  - lrck=1 for 32 bck; d bits 0..23 = 0xABCDEF MSB-first, then 8 zeros.
  - Right slot = 0x123456 followed by zeros.
- Same sample pair in RJ: left slot = 8 zeros then 0xABCDEF. In I2S: lrck=0 for the left slot, d = 0, 0xABCDEF, then 7 zeros.
- No s_valid after reset with en=1: underrun pulses at each frame start, d stays 0, s_ready stays 1.
- Hold s_valid=1 continuously with incrementing data:
  - Exactly one accept per frame; s_ready returns high 1 clk after each frame start.
  - Frames carry consecutive values with no underrun after the first frame.
- Change fmt from LJ to I2S at bit_cnt=10: the current frame completes as LJ and the next frame shows I2S lrck polarity and MSB delay.
- Drop en mid-frame, or assert rst mid-frame:
  - bck/lrck/d go to 0 the next clk.
  - After en returns, the held sample is preserved and appears in frame 0. After rst, s_ready=1 and the first frame underruns.

Source files
------------

// File: rtl/audio_serializer.sv
// Stereo PCM serializer producing lrck/bck/d in I2S, left-justified or right-justified
// format. The bit clock is divided down from clk. A one-deep holding register with a
// valid/ready handshake buffers the next sample pair, and an empty register at frame
// start is reported as an underrun.
module audio_serializer #(
  parameter int unsigned SLOT_BITS   = 32,
  parameter int unsigned SAMPLE_BITS = 24,
  parameter int unsigned HALF_DIV    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [1:0]                 fmt,
  input  logic [2*SAMPLE_BITS-1:0]   s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic                       lrck,
  output logic                       bck,
  output logic                       d,
  output logic                       frame_start,
  output logic                       underrun
);

  localparam int unsigned FrameBits = 2 * SLOT_BITS;
  localparam int unsigned DivW      = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int unsigned BitW      = $clog2(FrameBits);
  localparam int unsigned OffRj     = SLOT_BITS - SAMPLE_BITS;

  localparam logic [DivW-1:0] DivLast = DivW'(HALF_DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(FrameBits - 1);
  localparam logic [BitW-1:0] SlotCnt = BitW'(SLOT_BITS);

  typedef enum logic [1:0] {
    FmtI2s = 2'd0,
    FmtLj  = 2'd1,
    FmtRj  = 2'd2
  } fmt_e;

  // Divider and serial state
  logic [DivW-1:0]          div_cnt_q;
  logic                     bck_q;
  logic [BitW-1:0]          bit_cnt_q;
  logic                     lrck_q;
  logic                     d_q;
  logic                     fs_q;
  logic                     ur_q;
  logic [FrameBits-1:0]     shift_q;
  fmt_e                     fmt_q;

  // Holding register
  logic [2*SAMPLE_BITS-1:0] hold_q;
  logic                     hold_full_q;

  // Decoded per-cycle events
  logic                     div_wrap;
  logic                     fall;
  logic                     frame_go;
  logic                     accept;
  logic [BitW-1:0]          bit_cnt_nxt;
  logic                     lrck_nxt;
  fmt_e                     fmt_new;
  fmt_e                     fmt_cur;

  // Frame image construction
  logic [SAMPLE_BITS-1:0]   rev_l;
  logic [SAMPLE_BITS-1:0]   rev_r;
  logic [SLOT_BITS-1:0]     slot_l;
  logic [SLOT_BITS-1:0]     slot_r;
  logic [FrameBits-1:0]     img;
  int unsigned              off;

  assign div_wrap    = en && (div_cnt_q == DivLast);
  // A falling edge is the wrap that takes bck from 1 to 0.
  assign fall        = div_wrap && bck_q;
  assign bit_cnt_nxt = (bit_cnt_q == BitLast) ? '0 : bit_cnt_q + 1'b1;
  assign frame_go    = fall && (bit_cnt_q == BitLast);
  assign accept      = s_valid && !hold_full_q;

  // Decode the incoming format (3 aliases LJ) and pick the one governing this edge
  always_comb begin
    case (fmt)
      2'd0:    fmt_new = FmtI2s;
      2'd2:    fmt_new = FmtRj;
      default: fmt_new = FmtLj;
    endcase
    fmt_cur  = frame_go ? fmt_new : fmt_q;
    // Left slot is lrck=1 for LJ/RJ, inverted for I2S.
    lrck_nxt = (bit_cnt_nxt < SlotCnt) ^ (fmt_cur == FmtI2s);
  end

  // Build the transmit-order image (bit 0 goes out first) from the held sample pair
  always_comb begin
    rev_l = '0;
    rev_r = '0;
    for (int i = 0; i < int'(SAMPLE_BITS); i++) begin
      rev_l[i] = hold_q[2*SAMPLE_BITS-1-i];
      rev_r[i] = hold_q[SAMPLE_BITS-1-i];
    end
    case (fmt_new)
      FmtI2s:  off = 1;
      FmtRj:   off = OffRj;
      default: off = 0;
    endcase
    slot_l = SLOT_BITS'(rev_l) << off;
    slot_r = SLOT_BITS'(rev_r) << off;
    // An empty holding register transmits silence.
    img    = hold_full_q ? {slot_r, slot_l} : '0;
  end

  // Holding register: fill on handshake, drain when a frame starts with it full
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else if (accept) begin
      hold_q      <= s_data;
      hold_full_q <= 1'b1;
    end else if (frame_go) begin
      hold_full_q <= 1'b0;
    end
  end

  // Bit-clock divider, bit counter and serial outputs; all pins move on falling edges
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      bck_q     <= 1'b0;
      bit_cnt_q <= BitLast;
      lrck_q    <= 1'b0;
      d_q       <= 1'b0;
      fs_q      <= 1'b0;
      ur_q      <= 1'b0;
      shift_q   <= '0;
      fmt_q     <= FmtLj;
    end else begin
      fs_q <= 1'b0;
      ur_q <= 1'b0;
      if (!en) begin
        div_cnt_q <= '0;
        bck_q     <= 1'b0;
        bit_cnt_q <= BitLast;
        lrck_q    <= 1'b0;
        d_q       <= 1'b0;
        shift_q   <= '0;
      end else begin
        if (div_wrap) begin
          div_cnt_q <= '0;
          bck_q     <= ~bck_q;
        end else begin
          div_cnt_q <= div_cnt_q + 1'b1;
        end
        if (fall) begin
          bit_cnt_q <= bit_cnt_nxt;
          lrck_q    <= lrck_nxt;
          if (frame_go) begin
            fmt_q   <= fmt_new;
            d_q     <= img[0];
            shift_q <= img >> 1;
            fs_q    <= 1'b1;
            ur_q    <= ~hold_full_q;
          end else begin
            d_q     <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end
      end
    end
  end

  assign s_ready     = ~hold_full_q;
  assign lrck        = lrck_q;
  assign bck         = bck_q;
  assign d           = d_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;

endmodule

// File: tb/tb_audio_serializer.sv
// Randomised bench for audio_serializer. A frame-level reference model turns the
// handshake history and enable timing into expected frames (queued); a monitor pops
// them on each frame_start and compares the serial stream captured at bck rising edges.
module tb_audio_serializer;

  localparam int S = 32;
  localparam int N = 24;
  localparam int H = 2;
  localparam int F = 2 * S;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [1:0]     fmt;
  logic [2*N-1:0] s_data;
  logic           s_valid;
  logic           s_ready;
  logic           lrck;
  logic           bck;
  logic           d;
  logic           frame_start;
  logic           underrun;

  always #5 clk = ~clk;

  audio_serializer #(
    .SLOT_BITS   (S),
    .SAMPLE_BITS (N),
    .HALF_DIV    (H)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .fmt         (fmt),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .lrck        (lrck),
    .bck         (bck),
    .d           (d),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  typedef struct {
    int         cyc;
    bit         ur;
    logic [1:0] fmt;
    logic [N-1:0] l;
    logic [N-1:0] r;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  int             cyc = 0;
  int             t = 0;
  bit             m_full = 0;
  logic [2*N-1:0] m_hold = '0;
  bit             exp_bck = 0;
  bit             exp_fs = 0;
  bit             exp_ur = 0;
  bit             exp_ready = 1;
  bit             m_idle = 1;
  bit             mon_on = 0;

  // Monitor state
  bit           mon_active = 0;
  int           mon_pos = 0;
  frame_t       mon_cur;
  logic [F-1:0] cap_d;
  logic [F-1:0] cap_l;
  logic         prev_bck = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Expected serial image: slot offset is 1 for I2S, S-N for RJ, 0 for LJ; MSB first.
  function automatic logic [F-1:0] img_of(input frame_t f);
    logic [F-1:0] v = '0;
    int off;
    off = (f.fmt == 2'd0) ? 1 : (f.fmt == 2'd2) ? (S - N) : 0;
    for (int j = 0; j < N; j++) begin
      v[off + j]     = f.l[N-1-j];
      v[S + off + j] = f.r[N-1-j];
    end
    return v;
  endfunction

  function automatic logic [F-1:0] lr_of(input logic [1:0] f);
    logic [F-1:0] v = '0;
    for (int p = 0; p < F; p++) v[p] = (p < S) ^ (f == 2'd0);
    return v;
  endfunction

  // One clock of the model: t counts enabled cycles since (re)start; bck has toggled
  // (t+1)/H times after this edge, and every second toggle is a falling edge.
  task automatic model_step();
    bit     fs;
    bit     acc;
    int     tog;
    frame_t f;
    cyc++;
    fs = 0;
    if (rst) begin
      t = 0; m_full = 0; m_idle = 1;
      exp_bck = 0; exp_fs = 0; exp_ur = 0; exp_ready = 1;
      return;
    end
    acc = s_valid && !m_full;
    if (!en) begin
      t = 0; m_idle = 1; exp_bck = 0;
    end else begin
      m_idle = 0;
      tog = (t + 1) / H;
      exp_bck = (tog % 2) == 1;
      if (((t + 1) % H) == 0 && (tog % 2) == 0 && ((tog / 2 - 1) % F) == 0) fs = 1;
      t++;
    end
    exp_fs = fs;
    exp_ur = 0;
    if (fs) begin
      f.cyc = cyc;
      f.fmt = (fmt == 2'd3) ? 2'd1 : fmt;
      if (m_full) begin
        f.ur = 0; f.l = m_hold[2*N-1:N]; f.r = m_hold[N-1:0]; m_full = 0;
      end else begin
        f.ur = 1; f.l = '0; f.r = '0;
      end
      exp_ur = f.ur;
      exp_q.push_back(f);
    end
    if (acc) begin
      m_full = 1; m_hold = s_data;
    end
    exp_ready = !m_full;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: per-cycle pin checks plus frame-level comparison against the queue
  initial forever begin
    @(negedge clk);
    if (mon_on) begin
      chk("bck", 64'(bck), 64'(exp_bck));
      chk("s_ready", 64'(s_ready), 64'(exp_ready));
      chk("frame_start", 64'(frame_start), 64'(exp_fs));
      chk("underrun", 64'(underrun), 64'(exp_ur));
      if (m_idle) begin
        mon_active = 0;
        chk("idle_lrck", 64'(lrck), 64'(0));
        chk("idle_d", 64'(d), 64'(0));
      end
      if (frame_start === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_pop at cycle %0d: got frame_start expected none queued", cyc);
        end else begin
          mon_cur = exp_q.pop_front();
          chk("frame_cycle", 64'(cyc), 64'(mon_cur.cyc));
          chk("frame_underrun", 64'(underrun), 64'(mon_cur.ur));
          mon_active = 1; mon_pos = 0; cap_d = '0; cap_l = '0;
        end
      end else if (mon_active && bck === 1'b1 && prev_bck === 1'b0) begin
        cap_d[mon_pos] = d;
        cap_l[mon_pos] = lrck;
        mon_pos++;
        if (mon_pos == F) begin
          mon_active = 0;
          chk("frame_d", 64'(cap_d), 64'(img_of(mon_cur)));
          chk("frame_lrck", 64'(cap_l), 64'(lr_of(mon_cur.fmt)));
        end
      end
      prev_bck = bck;
    end
  end

  task automatic wait_fs();
    checks++;
    for (int i = 0; i < 4 * F * H + 8; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) return;
    end
    errors++;
    $display("FAIL wait_fs at cycle %0d: got no frame_start expected one", cyc);
  endtask

  // Called at a negedge; s_ready is registered, so its value here is what the next edge sees.
  task automatic send(input logic [2*N-1:0] v);
    s_data = v;
    s_valid = 1'b1;
    for (int i = 0; i < 4 * F * H; i++) begin
      if (s_ready === 1'b1) begin
        @(negedge clk);
        s_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    checks++; errors++;
    $display("FAIL send at cycle %0d: got no s_ready expected accept", cyc);
  endtask

  task automatic stream(input int n, input logic [2*N-1:0] base);
    bit ok;
    s_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      s_data = base + (2*N)'(k);
      ok = 0;
      for (int i = 0; i < 4 * F * H && !ok; i++) begin
        if (s_ready === 1'b1) ok = 1;
        @(negedge clk);
      end
      if (!ok) begin
        checks++; errors++;
        $display("FAIL stream at cycle %0d: got no s_ready expected accept", cyc);
      end
    end
    s_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; fmt = 2'd1; s_valid = 1'b0; s_data = '0;
    @(negedge clk);
    mon_on = 1;
    repeat (2) @(negedge clk);
    chk("rst_bck", 64'(bck), 64'(0));
    chk("rst_lrck", 64'(lrck), 64'(0));
    chk("rst_d", 64'(d), 64'(0));
    chk("rst_s_ready", 64'(s_ready), 64'(1));
    chk("rst_frame_start", 64'(frame_start), 64'(0));
    chk("rst_underrun", 64'(underrun), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    en = 1'b1;

    // Underrun frames with no source
    repeat (3) wait_fs();

    // Same pair in LJ, RJ, I2S
    fmt = 2'd1; send(48'hABCDEF_123456); wait_fs(); wait_fs();
    fmt = 2'd2; send(48'hABCDEF_123456); wait_fs(); wait_fs();
    fmt = 2'd0; send(48'hABCDEF_123456); wait_fs(); wait_fs();

    // Continuous valid with incrementing data
    fmt = 2'd1;
    stream(6, 48'h100000_000001);
    wait_fs(); wait_fs();

    // LJ -> I2S switch around bit 10 of a frame
    wait_fs();
    send(48'h5A5A5A_C3C3C3);
    repeat (10 * 2 * H - 1) @(negedge clk);
    fmt = 2'd0;
    send(48'h0F0F0F_F0F0F0);
    wait_fs(); wait_fs(); wait_fs();

    // Enable dropped mid-frame with a held sample
    fmt = 2'd1;
    wait_fs();
    fmt = 2'd2;
    send(48'h876543_FEDCBA);
    repeat (37) @(negedge clk);
    en = 1'b0;
    repeat (15) @(negedge clk);
    en = 1'b1;
    wait_fs(); wait_fs();

    // Reset mid-frame discards the held sample
    wait_fs();
    send(48'h2468AC_13579B);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_s_ready", 64'(s_ready), 64'(1));
    chk("midrst_bck", 64'(bck), 64'(0));
    rst = 1'b0;
    wait_fs(); wait_fs();

    // Random formats, data, gaps and enable blips
    for (int i = 0; i < 14; i++) begin
      fmt = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) send({24'($urandom), 24'($urandom)});
      repeat ($urandom_range(0, 300)) @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        en = 1'b0;
        repeat ($urandom_range(1, 20)) @(negedge clk);
        en = 1'b1;
      end
    end

    repeat (2 * F * H + 10) @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
